// File: rtl/sram_arb_pkg.sv
// Shared state encoding and default sizing for the SRAM arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W        = 20;
  localparam int DEF_DATA_W        = 16;
  localparam int DEF_ACCESS_CYCLES = 2;
  localparam int DEF_STARVE_LIMIT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RECOVER
  } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM bus bundle for the arbiter; slave is the arbiter side.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ack;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              busy;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_rdata,
    output rd_data, rd_ack, wr_ack, sram_addr, sram_wdata,
           sram_ce_n, sram_oe_n, sram_we_n, busy
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_rdata,
    input  rd_data, rd_ack, wr_ack, sram_addr, sram_wdata,
           sram_ce_n, sram_oe_n, sram_we_n, busy
  );

endinterface

// File: rtl/sram_access_timer.sv
// 4-bit down counter timing one SRAM strobe window; done marks its final cycle.
module sram_access_timer #(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load_i,
  output logic done_o
);

  localparam logic [3:0] LOAD_VAL = 4'(CYCLES);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter (display fetch vs frame writer), read priority.
// Define WR_STARVE_GUARD_EN to force a pending write after STARVE_LIMIT read grants.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
`ifdef WR_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
`endif
) (
  input  logic          clk,
  input  logic          n_rst,
  sram_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              rd_ack_q, rd_ack_d;
  logic              wr_ack_q, wr_ack_d;
  logic              grant_rd, grant_wr;
  logic              force_wr;
  logic              timer_done;

  sram_access_timer #(
    .CYCLES (ACCESS_CYCLES)
  ) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .load_i (grant_rd | grant_wr),
    .done_o (timer_done)
  );

`ifdef WR_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;

  // Only reads that overtook a waiting write count toward starvation.
  always_comb begin
    starve_d = starve_q;
    if (grant_wr) begin
      starve_d = '0;
    end else if (grant_rd && bus.wr_req) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_wr = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
  assign force_wr = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rd_req && !(force_wr && bus.wr_req)) begin
          grant_rd = 1'b1;
        end else if (bus.wr_req) begin
          grant_wr = 1'b1;
        end
      end
      ST_READ: begin
        if (timer_done) begin
          state_d = ST_RECOVER;
          rdata_d = bus.sram_rdata;
        end
      end
      ST_WRITE: begin
        if (timer_done) begin
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (grant_rd) begin
      state_d = ST_READ;
      is_wr_d = 1'b0;
      addr_d  = bus.rd_addr;
    end
    if (grant_wr) begin
      state_d = ST_WRITE;
      is_wr_d = 1'b1;
      addr_d  = bus.wr_addr;
      wdata_d = bus.wr_data;
    end

    // Strobes and acks are decoded from the next state so they leave flops.
    ce_n_d   = !((state_d == ST_READ) || (state_d == ST_WRITE));
    oe_n_d   = (state_d != ST_READ);
    we_n_d   = (state_d != ST_WRITE);
    rd_ack_d = (state_d == ST_RECOVER) && !is_wr_q;
    wr_ack_d = (state_d == ST_RECOVER) && is_wr_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign bus.rd_data    = rdata_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter at ACCESS_CYCLES=2; honours WR_STARVE_GUARD_EN.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   passed = 0;

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] strobes();
    return 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n});
  endfunction

  initial begin
    int   rd_cnt;
    int   wr_cnt;
    int   both_cnt;
    int   rd_before_wr;
    int   busy_cnt;
    logic wr_seen;

    n_rst          = 1'b0;
    bus.rd_req     = 1'b0;
    bus.wr_req     = 1'b0;
    bus.rd_addr    = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.sram_rdata = '0;
    #12;

    // Reset state
    check("rst_strobes", strobes(), 32'h7);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_acks", 32'({bus.rd_ack, bus.wr_ack}), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
    check("rst_sram_wdata", 32'(bus.sram_wdata), 32'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // Single read: strobes {ce,oe,we} = 3'b001 while reading
    bus.rd_addr    = 20'h00010;
    bus.sram_rdata = 16'hBEEF;
    bus.rd_req     = 1'b1;
    tick();
    check("rd_c1_strobes", strobes(), 32'h1);
    check("rd_c1_addr", 32'(bus.sram_addr), 32'h00010);
    check("rd_c1_busy", 32'(bus.busy), 32'd1);
    check("rd_c1_ack", 32'(bus.rd_ack), 32'd0);
    tick();
    check("rd_c2_strobes", strobes(), 32'h1);
    check("rd_c2_ack", 32'(bus.rd_ack), 32'd0);
    tick();
    check("rd_c3_ack", 32'({bus.rd_ack, bus.wr_ack}), 32'h2);
    check("rd_c3_strobes", strobes(), 32'h7);
    check("rd_c3_data", 32'(bus.rd_data), 32'hBEEF);
    $display("read  addr=0x%05h data=0x%04h", bus.sram_addr, bus.rd_data);
    bus.rd_req     = 1'b0;
    bus.sram_rdata = 16'h0000;
    tick();
    check("rd_c4_busy", 32'(bus.busy), 32'd0);
    check("rd_c4_ack", 32'(bus.rd_ack), 32'd0);
    check("rd_c4_data_held", 32'(bus.rd_data), 32'hBEEF);

    // Single write: strobes = 3'b010 while writing
    bus.wr_addr = 20'h3FFFF;
    bus.wr_data = 16'h1234;
    bus.wr_req  = 1'b1;
    tick();
    check("wr_c1_strobes", strobes(), 32'h2);
    check("wr_c1_addr", 32'(bus.sram_addr), 32'h3FFFF);
    check("wr_c1_wdata", 32'(bus.sram_wdata), 32'h1234);
    tick();
    check("wr_c2_strobes", strobes(), 32'h2);
    check("wr_c2_ack", 32'(bus.wr_ack), 32'd0);
    tick();
    check("wr_c3_ack", 32'({bus.rd_ack, bus.wr_ack}), 32'h1);
    check("wr_c3_strobes", strobes(), 32'h7);
    $display("write addr=0x%05h data=0x%04h", bus.sram_addr, bus.sram_wdata);
    bus.wr_req = 1'b0;
    tick();
    check("wr_c4_busy", 32'(bus.busy), 32'd0);

    // Simultaneous requests: read first, write granted from IDLE in cycle 4
    bus.rd_addr    = 20'h00022;
    bus.sram_rdata = 16'h5678;
    bus.wr_addr    = 20'h00033;
    bus.wr_data    = 16'hA5A5;
    bus.rd_req     = 1'b1;
    bus.wr_req     = 1'b1;
    tick();
    check("both_c1_strobes", strobes(), 32'h1);
    check("both_c1_addr", 32'(bus.sram_addr), 32'h00022);
    tick();
    tick();
    check("both_c3_acks", 32'({bus.rd_ack, bus.wr_ack}), 32'h2);
    check("both_c3_data", 32'(bus.rd_data), 32'h5678);
    $display("read  addr=0x%05h data=0x%04h", bus.sram_addr, bus.rd_data);
    bus.rd_req = 1'b0;
    tick();
    check("both_c4_idle", 32'(bus.busy), 32'd0);
    tick();
    check("both_c5_strobes", strobes(), 32'h2);
    check("both_c5_addr", 32'(bus.sram_addr), 32'h00033);
    check("both_c5_wdata", 32'(bus.sram_wdata), 32'hA5A5);
    tick();
    check("both_c6_ack", 32'(bus.wr_ack), 32'd0);
    tick();
    check("both_c7_acks", 32'({bus.rd_ack, bus.wr_ack}), 32'h1);
    $display("write addr=0x%05h data=0x%04h", bus.sram_addr, bus.sram_wdata);
    bus.wr_req = 1'b0;
    tick();

    // Both held high for 24 cycles
    bus.rd_addr    = 20'h00100;
    bus.sram_rdata = 16'hC0DE;
    bus.wr_addr    = 20'h00200;
    bus.wr_data    = 16'h9999;
    bus.rd_req     = 1'b1;
    bus.wr_req     = 1'b1;
    rd_cnt         = 0;
    wr_cnt         = 0;
    both_cnt       = 0;
    rd_before_wr   = 0;
    wr_seen        = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (bus.rd_ack && bus.wr_ack) both_cnt++;
      if (bus.wr_ack) begin
        wr_cnt++;
        wr_seen = 1'b1;
      end
      if (bus.rd_ack) begin
        rd_cnt++;
        if (!wr_seen) rd_before_wr++;
      end
    end
    $display("held  reads=%0d writes=%0d", rd_cnt, wr_cnt);
`ifdef WR_STARVE_GUARD_EN
    check("guard_reads_before_write", 32'(rd_before_wr), 32'd4);
    check("guard_write_acks", 32'(wr_cnt), 32'd1);
    check("guard_total_reads", 32'(rd_cnt), 32'd5);
`else
    check("strict_write_acks", 32'(wr_cnt), 32'd0);
    check("strict_total_reads", 32'(rd_cnt), 32'd6);
`endif
    check("acks_exclusive", 32'(both_cnt), 32'd0);
    bus.rd_req = 1'b0;
    wr_seen    = 1'b0;
    for (int i = 0; i < 12 && !wr_seen; i++) begin
      tick();
      if (bus.wr_ack) wr_seen = 1'b1;
    end
    bus.wr_req = 1'b0;
    check("pending_write_ack", 32'(wr_seen), 32'd1);
    tick();
    check("pending_write_idle", 32'(bus.busy), 32'd0);

    // Reset asserted during write cycle 2
    bus.wr_addr = 20'h00055;
    bus.wr_data = 16'h7777;
    bus.wr_req  = 1'b1;
    tick();
    tick();
    check("rstw_c2_strobes", strobes(), 32'h2);
    #2;
    n_rst = 1'b0;
    #1;
    check("rstw_strobes", strobes(), 32'h7);
    check("rstw_ack", 32'(bus.wr_ack), 32'd0);
    check("rstw_busy", 32'(bus.busy), 32'd0);
    check("rstw_rd_data", 32'(bus.rd_data), 32'd0);
    check("rstw_sram_addr", 32'(bus.sram_addr), 32'd0);
    bus.wr_req = 1'b0;
    tick();
    n_rst    = 1'b1;
    wr_cnt   = 0;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.wr_ack) wr_cnt++;
      if (bus.busy) busy_cnt++;
    end
    $display("reset during write, abandoned");
    check("rstw_no_late_ack", 32'(wr_cnt), 32'd0);
    check("rstw_no_retry", 32'(busy_cnt), 32'd0);

    // Read request dropped right after grant
    bus.rd_addr    = 20'h00077;
    bus.sram_rdata = 16'h0F0F;
    bus.rd_req     = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("drop_c1_strobes", strobes(), 32'h1);
    tick();
    tick();
    check("drop_c3_ack", 32'(bus.rd_ack), 32'd1);
    check("drop_c3_data", 32'(bus.rd_data), 32'h0F0F);
    $display("read  addr=0x%05h data=0x%04h (req dropped)", bus.sram_addr, bus.rd_data);
    tick();
    check("drop_c4_ack", 32'(bus.rd_ack), 32'd0);
    check("drop_c4_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM address width (matches the 20-bit pixel address counter).
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 Parameter ACCESS_CYCLES, default 2, cycles a strobe is held per access; legal range 1..15.
REQ-004 Parameter STARVE_LIMIT, default 4, consecutive read grants before a pending write is forced (guard build only).
REQ-005 clk  input  1  single system clock; all state changes on rising edge.
REQ-006 n_rst  input  1  asynchronous, active-low reset.
REQ-007 rd_req  input  1  display-fetch request; held high until rd_ack.
REQ-008 rd_addr  input  ADDR_W  fetch address; stable while rd_req high.
REQ-009 rd_data  output  DATA_W  fetched word; valid while rd_ack high, held until the next read completes.
REQ-010 rd_ack  output  1  one-cycle pulse: read complete.
REQ-011 wr_req  input  1  frame-writer request; held high until wr_ack.
REQ-012 wr_addr / wr_data  input  ADDR_W / DATA_W  write address and data; stable while wr_req high.
REQ-013 wr_ack  output  1  one-cycle pulse: write complete.
REQ-014 sram_addr / sram_wdata  output  ADDR_W / DATA_W  registered SRAM bus.
REQ-015 sram_rdata  input  DATA_W  SRAM read bus.
REQ-016 sram_ce_n / sram_oe_n / sram_we_n  output  1 each  active-low SRAM strobes, registered.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, READ, WRITE, RECOVER.
REQ-019 IDLE: rd_req high -> READ; else wr_req high -> WRITE; both high -> READ (unless REQ-030 applies).
REQ-020 On grant edge, sram_addr (and sram_wdata for writes) latch from the granted requester's inputs.
REQ-021 READ: ce_n=0, oe_n=0, we_n=1 for exactly ACCESS_CYCLES cycles; on the last of these edges rd_data <= sram_rdata and state -> RECOVER.
REQ-022 WRITE: ce_n=0, we_n=0, oe_n=1 for exactly ACCESS_CYCLES cycles, then RECOVER.
REQ-023 RECOVER: one cycle, all strobes 1 (bus turnaround); matching ack high this cycle only; then IDLE.
REQ-024 Latency: request sampled in IDLE at edge 0 -> ack high in cycle ACCESS_CYCLES+1; sustained throughput one access per ACCESS_CYCLES+2 cycles.
REQ-025 Requests are arbitrated only in IDLE; requests present during READ/WRITE/RECOVER wait.
REQ-026 Requester dropping req after grant: access completes, ack still pulses; no abort.
REQ-027 rd_ack and wr_ack are never high in the same cycle.

Reset
REQ-028 n_rst low asynchronously forces: state IDLE, all strobes 1, rd_ack=wr_ack=0, busy=0, rd_data=0, sram_addr=0, sram_wdata=0, timer and starve counter 0.
REQ-029 Reset mid-access abandons the access; no ack issued, no retry after release.

Configuration
REQ-030 Macro WR_STARVE_GUARD_EN defined: counter increments on each read grant made while wr_req high, clears on any write grant; when counter == STARVE_LIMIT and both requests are high in IDLE, WRITE is granted.
REQ-031 Macro undefined: strict read priority; counter logic absent.

Structure
REQ-032 Package sram_arb_pkg holds the state enum typedef and default values for ADDR_W, DATA_W, ACCESS_CYCLES.
REQ-033 Sub-module sram_access_timer: 4-bit down counter, loaded with ACCESS_CYCLES on grant, asserts done on its final cycle.

Verification (ACCESS_CYCLES=2)
REQ-034 Single read: rd_req=1, rd_addr=0x00010, sram_rdata=0xBEEF -> ce_n/oe_n low cycles 1-2, rd_ack high cycle 3, rd_data=0xBEEF, busy low cycle 4.
REQ-035 Single write: wr_addr=0x3FFFF, wr_data=0x1234 -> we_n low cycles 1-2 with sram_addr=0x3FFFF, sram_wdata=0x1234; wr_ack high cycle 3.
REQ-036 Simultaneous rd_req and wr_req -> read ack cycle 3, write granted in IDLE cycle 4, wr_ack cycle 7.
REQ-037 Guard build, STARVE_LIMIT=4, rd_req and wr_req held high -> four read acks, then write granted; without macro, no wr_ack while rd_req is held high.
REQ-038 n_rst pulsed low during WRITE cycle 2 -> strobes high immediately, no wr_ack, state IDLE, rd_data=0.
REQ-039 rd_req dropped in READ cycle 1 -> rd_ack still pulses in cycle 3.
